// File: rtl/espi_arb_pkg.sv
// Shared types and default widths for the eSPI transaction arbiter and its helpers.
package espi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int unsigned ESPI_CMD_W  = 8;
  localparam int unsigned ESPI_DATA_W = 8;

endpackage

// File: rtl/espi_rr_picker.sv
// Combinational round-robin search: first set req bit after last_gnt, with wrap.
module espi_rr_picker
  import espi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int unsigned cand;

  // Walk candidates last_gnt+1 .. last_gnt+NUM_REQ; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_gnt) + i) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/espi_txn_arbiter.sv
// Round-robin arbiter sharing one eSPI transaction port, one transaction outstanding at a time.
// Optional WAIT watchdog built when ESPI_ARB_TIMEOUT_EN is defined.
module espi_txn_arbiter
  import espi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned CMD_W          = ESPI_CMD_W,
  parameter int unsigned DATA_W         = ESPI_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      start_transaction,
  output logic [CMD_W-1:0]          command,
  output logic [DATA_W-1:0]         write_data,
  input  logic [DATA_W-1:0]         read_data,
  input  logic                      transaction_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_param_err
    $error("espi_txn_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_e         state;
  logic [IDX_W-1:0]   last_gnt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [CMD_W-1:0]   cmd_slot   [NUM_REQ];
  logic [DATA_W-1:0]  wdata_slot [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign cmd_slot[i]   = req_cmd[i*CMD_W +: CMD_W];
    assign wdata_slot[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  espi_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req      (req),
    .last_gnt (last_gnt),
    .found    (pick_found),
    .idx      (pick_idx)
  );

`ifdef ESPI_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  // Transaction sequencer; gnt/start/rsp_valid are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      last_gnt          <= IDX_W'(NUM_REQ - 1);
      owner             <= '0;
      gnt               <= '0;
      rsp_valid         <= '0;
      rsp_rdata         <= '0;
      busy              <= 1'b0;
      start_transaction <= 1'b0;
      command           <= '0;
      write_data        <= '0;
`ifdef ESPI_ARB_TIMEOUT_EN
      tmo_cnt           <= '0;
      rsp_err           <= 1'b0;
`endif
    end else begin
      gnt               <= '0;
      rsp_valid         <= '0;
      start_transaction <= 1'b0;
`ifdef ESPI_ARB_TIMEOUT_EN
      rsp_err           <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner             <= pick_idx;
            command           <= cmd_slot[pick_idx];
            write_data        <= wdata_slot[pick_idx];
            gnt               <= NUM_REQ'(1) << pick_idx;
            start_transaction <= 1'b1;
            busy              <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          last_gnt <= owner;
`ifdef ESPI_ARB_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
          state    <= WAIT;
        end
        WAIT: begin
          // A done coinciding with watchdog expiry still completes normally.
          if (transaction_done) begin
            rsp_rdata <= read_data;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= RESP;
          end
`ifdef ESPI_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
